uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters to one UART transmitter; one GRANT cycle, then SEND until done edge or timeout, then GAP.
// Latency: request seen in IDLE -> req_ready/tx_input next cycle; requesters are held off until their one-cycle req_ready pulse.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 1
) (
    input  logic                   tx_clock,
    input  logic                   tx_reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_enable,
    output logic [7:0]             tx_input,
    input  logic                   tx_done,
    input  logic                   tx_busy,
    output logic [2:0]             grant_id,
    output logic                   arb_busy,
    output logic                   timeout_err
);

    localparam int TO_W = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]      GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        last_ptr;
    logic [TO_W-1:0]   to_cnt;
    logic [3:0]        gap_cnt;
    logic              tx_done_q;
    logic              done_edge;

    logic              win_found;
    logic [2:0]        win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [7:0]        win_data;
    int                cand;

    // Transmitter busy is informational only; sequencing relies on tx_done.
    wire unused_tx_busy = tx_busy;

    assign done_edge = tx_done & ~tx_done_q;

    // Search starts one past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = 3'd0;
        win_onehot = '0;
        win_data   = 8'd0;
        cand       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_valid[cand]) begin
                win_found        = 1'b1;
                win_idx          = 3'(cand);
                win_onehot[cand] = 1'b1;
                win_data         = req_data[8*cand +: 8];
            end
        end
    end

    always_ff @(posedge tx_clock) begin
        if (tx_reset) begin
            state       <= IDLE;
            last_ptr    <= 3'(NUM_REQ - 1);
            to_cnt      <= '0;
            gap_cnt     <= 4'd0;
            tx_done_q   <= 1'b0;
            req_ready   <= '0;
            tx_enable   <= 1'b0;
            tx_input    <= 8'd0;
            grant_id    <= 3'd0;
            arb_busy    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_done_q   <= tx_done;
            req_ready   <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state     <= GRANT;
                        arb_busy  <= 1'b1;
                        req_ready <= win_onehot;
                        grant_id  <= win_idx;
                        last_ptr  <= win_idx;
                        tx_input  <= win_data;
                    end
                end
                GRANT: begin
                    state     <= SEND;
                    tx_enable <= 1'b1;
                    to_cnt    <= '0;
                end
                SEND: begin
                    // A done edge in the timeout cycle still counts as a clean completion.
                    if (done_edge) begin
                        state     <= GAP;
                        tx_enable <= 1'b0;
                        gap_cnt   <= 4'd0;
                    end else if (to_cnt == TO_LAST) begin
                        state       <= GAP;
                        tx_enable   <= 1'b0;
                        gap_cnt     <= 4'd0;
                        timeout_err <= 1'b1;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                    end else if (gap_cnt != 4'hF) begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
